// File: rtl/smart_home_pkg.sv
// Shared smart-home constants: config/key widths, reset key and the
// config-memory FSM state encoding used by config_memory_unit.
package smart_home_pkg;

    localparam int CFG_W = 35;
    localparam int KEY_W = 2;
    localparam logic [1:0] RESET_KEY = 2'b10;

    typedef enum logic [1:0] {
        CMU_IDLE    = 2'b00,
        CMU_CAPTURE = 2'b01,
        CMU_COMMIT  = 2'b10
    } cmu_state_e;

endpackage

// File: rtl/config_memory_unit_if.sv
// Bus between the control unit / device drivers and config_memory_unit.
interface config_memory_unit_if #(
    parameter int CFG_W = 35,
    parameter int KEY_W = 2,
    parameter int CNT_W = 8
);
    logic             write_en;
    logic [CFG_W-1:0] configin;
    logic             key_load;
    logic [KEY_W-1:0] key_new;
    logic [KEY_W-1:0] syskey;
    logic [CFG_W-1:0] config_q;
    logic             config_valid;
    logic             update_pulse;
    logic             key_rej;
    logic [CNT_W-1:0] write_count;
    logic [1:0]       dbg_state;

    modport master (
        output write_en, configin, key_load, key_new,
        input  syskey, config_q, config_valid, update_pulse, key_rej,
               write_count, dbg_state
    );

    modport slave (
        input  write_en, configin, key_load, key_new,
        output syskey, config_q, config_valid, update_pulse, key_rej,
               write_count, dbg_state
    );
endinterface

// File: rtl/config_memory_unit_sat_counter.sv
// Width-parameterised counter that increments on en and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
endmodule

// File: rtl/config_memory_unit.sv
// Config memory stage: stages a write session, commits it atomically on close
// if changed, guards key reload. Optional parity check under CFG_PARITY_EN.
module config_memory_unit #(
    parameter int               CFG_W     = smart_home_pkg::CFG_W,
    parameter int               KEY_W     = smart_home_pkg::KEY_W,
    parameter int               CNT_W     = 8,
    parameter logic [KEY_W-1:0] RESET_KEY = smart_home_pkg::RESET_KEY,
    parameter logic [CFG_W-1:0] RESET_CFG = '0
) (
    input  logic clk,
    input  logic arst,
`ifdef CFG_PARITY_EN
    input  logic parity_force,
    output logic parity_err,
`endif
    config_memory_unit_if.slave bus
);
    import smart_home_pkg::*;

    cmu_state_e       state_q, state_d;
    logic [CFG_W-1:0] staging_q, staging_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [KEY_W-1:0] syskey_q, syskey_d;
    logic             valid_q, valid_d;
    logic             update_pulse_q, update_pulse_d;
    logic             key_rej_q, key_rej_d;
    logic             commit_fire;
    logic             key_idle;

    // Key reload is only safe with no session open or starting this cycle.
    assign key_idle = (state_q == CMU_IDLE) && !bus.write_en;

    always_comb begin
        state_d        = state_q;
        staging_d      = staging_q;
        cfg_d          = cfg_q;
        syskey_d       = syskey_q;
        valid_d        = valid_q;
        update_pulse_d = 1'b0;
        key_rej_d      = 1'b0;
        commit_fire    = 1'b0;

        case (state_q)
            CMU_IDLE: begin
                if (bus.write_en) begin
                    staging_d = bus.configin;
                    state_d   = CMU_CAPTURE;
                end
            end
            CMU_CAPTURE: begin
                if (bus.write_en) begin
                    staging_d = bus.configin;
                end else if (staging_q != cfg_q) begin
                    state_d = CMU_COMMIT;
                end else begin
                    state_d = CMU_IDLE;
                end
            end
            CMU_COMMIT: begin
                cfg_d          = staging_q;
                update_pulse_d = 1'b1;
                valid_d        = 1'b1;
                commit_fire    = 1'b1;
                if (bus.write_en) begin
                    staging_d = bus.configin;
                    state_d   = CMU_CAPTURE;
                end else begin
                    state_d = CMU_IDLE;
                end
            end
            default: begin
                state_d = CMU_IDLE;
            end
        endcase

        if (bus.key_load) begin
            if (key_idle) begin
                syskey_d = bus.key_new;
            end else if (state_q != CMU_IDLE || bus.write_en) begin
                if (state_q == CMU_IDLE || state_q == CMU_CAPTURE || state_q == CMU_COMMIT) begin
                    key_rej_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q        <= CMU_IDLE;
            staging_q      <= RESET_CFG;
            cfg_q          <= RESET_CFG;
            syskey_q       <= RESET_KEY;
            valid_q        <= 1'b0;
            update_pulse_q <= 1'b0;
            key_rej_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            staging_q      <= staging_d;
            cfg_q          <= cfg_d;
            syskey_q       <= syskey_d;
            valid_q        <= valid_d;
            update_pulse_q <= update_pulse_d;
            key_rej_q      <= key_rej_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_write_count (
        .clk   (clk),
        .arst  (arst),
        .en    (commit_fire),
        .count (bus.write_count)
    );

`ifdef CFG_PARITY_EN
    logic parity_q, parity_d;
    logic parity_err_q, parity_err_d;

    // Even parity of the committed word; force flips the stored bit as seen by the checker.
    always_comb begin
        parity_d     = commit_fire ? (^staging_q) : parity_q;
        parity_err_d = (^cfg_q) != (parity_q ^ parity_force);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            parity_q     <= ^RESET_CFG;
            parity_err_q <= 1'b0;
        end else begin
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign bus.syskey       = syskey_q;
    assign bus.config_q     = cfg_q;
    assign bus.config_valid = valid_q;
    assign bus.update_pulse = update_pulse_q;
    assign bus.key_rej      = key_rej_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_config_memory_unit.sv
// Bench for config_memory_unit: directed table, reset/saturation sequences and
// randomized traffic against a session-level reference model.
module tb_config_memory_unit;

    logic clk;
    logic arst;
`ifdef CFG_PARITY_EN
    logic parity_force;
    logic parity_err;
`endif

    config_memory_unit_if #(.CFG_W(35), .KEY_W(2), .CNT_W(8)) bus ();

    config_memory_unit dut (
        .clk          (clk),
        .arst         (arst),
`ifdef CFG_PARITY_EN
        .parity_force (parity_force),
        .parity_err   (parity_err),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: session open / commit pending, not a state encoding copy.
    logic [1:0]  m_key;
    logic [34:0] m_cfg;
    logic [34:0] m_stg;
    logic        m_valid;
    logic        m_upd;
    logic        m_rej;
    logic [7:0]  m_cnt;
    bit          m_open;
    bit          m_pending;

    typedef struct {
        logic        we;
        logic [34:0] cin;
        logic        kl;
        logic [1:0]  kn;
        logic [1:0]  e_key;
        logic [34:0] e_cfg;
        logic        e_v;
        logic        e_u;
        logic        e_r;
        logic [7:0]  e_cnt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_key = 2'b10; m_cfg = '0; m_stg = '0; m_valid = 0;
        m_upd = 0; m_rej = 0; m_cnt = 0; m_open = 0; m_pending = 0;
    endtask

    task automatic model_edge(input logic we, input logic [34:0] cin,
                              input logic kl, input logic [1:0] kn);
        bit busy;
        busy  = m_open || m_pending || we;
        m_upd = 0;
        m_rej = 0;
        if (kl) begin
            if (busy) m_rej = 1;
            else      m_key = kn;
        end
        if (m_pending) begin
            m_cfg = m_stg; m_upd = 1; m_valid = 1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
            m_pending = 0;
            m_open = we;
            if (we) m_stg = cin;
        end else if (m_open) begin
            if (we) m_stg = cin;
            else begin
                m_open = 0;
                m_pending = (m_stg != m_cfg);
            end
        end else if (we) begin
            m_stg = cin;
            m_open = 1;
        end
    endtask

    function automatic logic [1:0] model_state();
        if (m_open)    return 2'b01;
        if (m_pending) return 2'b10;
        return 2'b00;
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".syskey"},       bus.syskey,       m_key);
        chk({tag, ".config_q"},     bus.config_q,     m_cfg);
        chk({tag, ".config_valid"}, bus.config_valid, m_valid);
        chk({tag, ".update_pulse"}, bus.update_pulse, m_upd);
        chk({tag, ".key_rej"},      bus.key_rej,      m_rej);
        chk({tag, ".write_count"},  bus.write_count,  m_cnt);
        chk({tag, ".dbg_state"},    bus.dbg_state,    model_state());
    endtask

    task automatic cyc(input string tag, input logic we, input logic [34:0] cin,
                       input logic kl, input logic [1:0] kn);
        bus.write_en = we;
        bus.configin = cin;
        bus.key_load = kl;
        bus.key_new  = kn;
        @(posedge clk);
        model_edge(we, cin, kl, kn);
        #1;
        compare_model(tag);
    endtask

    initial begin
        logic [63:0] rnd;
        logic [34:0] cin;
        logic        we;
        total = 0;
        bad   = 0;
        arst  = 1'b0;
        bus.write_en = 0; bus.configin = '0; bus.key_load = 0; bus.key_new = '0;
`ifdef CFG_PARITY_EN
        parity_force = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_model("reset");
`ifdef CFG_PARITY_EN
        chk("reset.parity_err", parity_err, 1'b0);
`endif
        @(negedge clk);
        arst = 1'b1;
        for (int i = 0; i < 5; i++) cyc("idle", 0, '0, 0, '0);

        tbl[0]  = '{0, 35'h0,          0, 2'd0, 2'd2, 35'h0,  0, 0, 0, 8'd0, 2'd0};
        tbl[1]  = '{1, 35'h1_2345_6789, 0, 2'd0, 2'd2, 35'h0,  0, 0, 0, 8'd0, 2'd1};
        tbl[2]  = '{1, 35'hFF,         0, 2'd0, 2'd2, 35'h0,  0, 0, 0, 8'd0, 2'd1};
        tbl[3]  = '{1, 35'hFF,         0, 2'd0, 2'd2, 35'h0,  0, 0, 0, 8'd0, 2'd1};
        tbl[4]  = '{0, 35'h0,          0, 2'd0, 2'd2, 35'h0,  0, 0, 0, 8'd0, 2'd2};
        tbl[5]  = '{0, 35'h0,          0, 2'd0, 2'd2, 35'hFF, 1, 1, 0, 8'd1, 2'd0};
        tbl[6]  = '{0, 35'h0,          0, 2'd0, 2'd2, 35'hFF, 1, 0, 0, 8'd1, 2'd0};
        tbl[7]  = '{1, 35'hFF,         0, 2'd0, 2'd2, 35'hFF, 1, 0, 0, 8'd1, 2'd1};
        tbl[8]  = '{0, 35'h0,          0, 2'd0, 2'd2, 35'hFF, 1, 0, 0, 8'd1, 2'd0};
        tbl[9]  = '{0, 35'h0,          0, 2'd0, 2'd2, 35'hFF, 1, 0, 0, 8'd1, 2'd0};
        tbl[10] = '{0, 35'h0,          1, 2'd1, 2'd1, 35'hFF, 1, 0, 0, 8'd1, 2'd0};
        tbl[11] = '{1, 35'hFF,         1, 2'd3, 2'd1, 35'hFF, 1, 0, 1, 8'd1, 2'd1};
        tbl[12] = '{0, 35'h0,          0, 2'd0, 2'd1, 35'hFF, 1, 0, 0, 8'd1, 2'd0};
        tbl[13] = '{1, 35'hAA,         0, 2'd0, 2'd1, 35'hFF, 1, 0, 0, 8'd1, 2'd1};
        tbl[14] = '{0, 35'h0,          1, 2'd3, 2'd1, 35'hFF, 1, 0, 1, 8'd1, 2'd2};
        tbl[15] = '{1, 35'hBB,         0, 2'd0, 2'd1, 35'hAA, 1, 1, 0, 8'd2, 2'd1};
        tbl[16] = '{0, 35'h0,          0, 2'd0, 2'd1, 35'hAA, 1, 0, 0, 8'd2, 2'd2};
        tbl[17] = '{0, 35'h0,          0, 2'd0, 2'd1, 35'hBB, 1, 1, 0, 8'd3, 2'd0};
        tbl[18] = '{0, 35'h0,          0, 2'd0, 2'd1, 35'hBB, 1, 0, 0, 8'd3, 2'd0};

        for (int i = 0; i < 19; i++) begin
            cyc("tbl_model", tbl[i].we, tbl[i].cin, tbl[i].kl, tbl[i].kn);
            chk($sformatf("tbl%0d.syskey", i),       bus.syskey,       tbl[i].e_key);
            chk($sformatf("tbl%0d.config_q", i),     bus.config_q,     tbl[i].e_cfg);
            chk($sformatf("tbl%0d.config_valid", i), bus.config_valid, tbl[i].e_v);
            chk($sformatf("tbl%0d.update_pulse", i), bus.update_pulse, tbl[i].e_u);
            chk($sformatf("tbl%0d.key_rej", i),      bus.key_rej,      tbl[i].e_r);
            chk($sformatf("tbl%0d.write_count", i),  bus.write_count,  tbl[i].e_cnt);
            chk($sformatf("tbl%0d.dbg_state", i),    bus.dbg_state,    tbl[i].e_st);
        end

        // Reset in the middle of a session: nothing of it may ever commit.
        cyc("midrst", 1, 35'h7_FFFF_FFFF, 0, '0);
        cyc("midrst", 1, 35'h7_FFFF_FFFF, 0, '0);
        #2;
        arst = 1'b0;
        #1;
        model_reset();
        compare_model("midrst.async");
        @(negedge clk);
        arst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("postrst", 0, '0, 0, '0);
            chk("postrst.update_pulse", bus.update_pulse, 1'b0);
            chk("postrst.config_q", bus.config_q, 35'h0);
            chk("postrst.write_count", bus.write_count, 8'h0);
        end

        // 256 one-cycle sessions with distinct values push the counter past saturation.
        for (int i = 1; i <= 256; i++) begin
            cyc("sat", 1, 35'(i), 0, '0);
            cyc("sat", 0, '0, 0, '0);
            cyc("sat", 0, '0, 0, '0);
        end
        chk("sat.write_count", bus.write_count, 8'hFF);
        chk("sat.config_q", bus.config_q, 35'd256);
        chk("sat.update_pulse", bus.update_pulse, 1'b1);
        cyc("sat_after", 0, '0, 0, '0);
        chk("sat_after.update_pulse", bus.update_pulse, 1'b0);

`ifdef CFG_PARITY_EN
        chk("parity.clean", parity_err, 1'b0);
        parity_force = 1'b1;
        cyc("parity", 0, '0, 0, '0);
        chk("parity.forced", parity_err, 1'b1);
        parity_force = 1'b0;
        cyc("parity", 0, '0, 0, '0);
        chk("parity.released", parity_err, 1'b0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       cin = m_cfg;
                1:       cin = 35'h0;
                2:       cin = 35'($urandom_range(0, 7));
                default: cin = rnd[34:0];
            endcase
            we = ($urandom_range(0, 99) < 55);
            cyc("rand", we, cin, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
